// File: rtl/mux_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | mux_pkg : shared types, mode encodings and bus-slicing helper for  |
// |           the N:1 scanning mux family.                             |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package mux_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_t;

  localparam logic MODE_MANUAL = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

  // Upper bounds for the generic slicing helper: total bus bits and bits per channel.
  localparam int unsigned BUS_MAX_W   = 1024;
  localparam int unsigned BUS_IDX_W   = 10;
  localparam int unsigned CH_MAX_W    = 64;
  localparam int unsigned CH_IDX_W    = 6;

  function automatic logic [CH_MAX_W-1:0] ch_extract(
    input logic [BUS_MAX_W-1:0] bus,
    input int unsigned          k,
    input int unsigned          w
  );
    logic [CH_MAX_W-1:0] r;
    r = '0;
    for (int unsigned b = 0; b < CH_MAX_W; b++) begin
      if ((b < w) && ((k * w + b) < BUS_MAX_W)) begin
        r[CH_IDX_W'(b)] = bus[BUS_IDX_W'(k * w + b)];
      end
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mux_nx1_comb.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | mux_nx1_comb : parametrised combinational N:1 select; an index at  |
// |                or beyond N_CH yields zero.                         |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module mux_nx1_comb
  import mux_pkg::*;
#(
  parameter  int N_CH = 4,
  parameter  int W    = 1,
  localparam int SW   = $clog2(N_CH)
) (
  input  logic [N_CH*W-1:0] i_data,
  input  logic [SW-1:0]     i_sel,
  output logic [W-1:0]      o_data
);

  logic [BUS_MAX_W-1:0] w_bus;

  assign w_bus = BUS_MAX_W'(i_data);

  always_comb begin
    o_data = '0;
    for (int k = 0; k < N_CH; k++) begin
      if (i_sel == SW'(k)) begin
        o_data = W'(ch_extract(w_bus, k, W));
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/mux_scan_nx1.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | mux_scan_nx1 : registered N:1 mux with manual select and a timed   |
// |                auto-scan sweep across all channels.                |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module mux_scan_nx1
  import mux_pkg::*;
#(
  parameter  int N_CH    = 4,
  parameter  int W       = 1,
  parameter  int DWELL_W = 4,
  localparam int SW      = $clog2(N_CH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_CH*W-1:0]    I,
  input  logic [SW-1:0]        S,
  input  logic                 mode,
  input  logic                 start,
  input  logic [DWELL_W-1:0]   dwell,
  output logic [W-1:0]         Y,
  output logic [SW-1:0]        ch,
  output logic                 valid,
  output logic                 busy,
  output logic                 scan_done
);

  localparam logic [SW:0]   c_nch  = (SW+1)'(N_CH);
  localparam logic [SW-1:0] c_last = SW'(N_CH - 1);

  state_t               r_state;
  logic [SW-1:0]        r_idx;
  logic [DWELL_W-1:0]   r_cnt;
  logic [DWELL_W-1:0]   r_dwell;
  logic [W-1:0]         r_y;
  logic [SW-1:0]        r_ch;
  logic                 r_valid;
  logic                 r_busy;
  logic                 r_done;

  logic [SW-1:0]        w_sel;
  logic [W-1:0]         w_mux;
  logic                 w_in_range;

  assign w_sel      = (r_state == SCAN) ? r_idx : S;
  assign w_in_range = ({1'b0, S} < c_nch);

  mux_nx1_comb #(
    .N_CH (N_CH),
    .W    (W)
  ) u_mux (
    .i_data (I),
    .i_sel  (w_sel),
    .o_data (w_mux)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_idx   <= '0;
      r_cnt   <= '0;
      r_dwell <= '0;
      r_y     <= '0;
      r_ch    <= '0;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          r_busy <= 1'b0;
          if (mode == MODE_MANUAL) begin
            r_y     <= w_mux;
            r_ch    <= S;
            r_valid <= w_in_range;
          end else begin
            r_valid <= 1'b0;
            if (start) begin
              r_dwell <= dwell;
              r_idx   <= '0;
              r_cnt   <= '0;
              r_state <= SCAN;
              r_busy  <= 1'b1;
            end
          end
        end
        SCAN: begin
          if (mode == MODE_MANUAL) begin
            // Abort: outputs hold this edge, manual select takes over on the next.
            r_state <= IDLE;
            r_busy  <= 1'b0;
            r_valid <= 1'b0;
          end else begin
            r_y     <= w_mux;
            r_ch    <= r_idx;
            r_valid <= 1'b1;
            if (r_cnt == r_dwell) begin
              r_cnt <= '0;
              if (r_idx == c_last) begin
                r_state <= IDLE;
                r_busy  <= 1'b0;
                r_done  <= 1'b1;
              end else begin
                r_idx <= r_idx + SW'(1);
              end
            end else begin
              r_cnt <= r_cnt + DWELL_W'(1);
            end
          end
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign Y         = r_y;
  assign ch        = r_ch;
  assign valid     = r_valid;
  assign busy      = r_busy;
  assign scan_done = r_done;

endmodule
`default_nettype wire

// File: tb/tb_mux_scan_nx1.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_mux_scan_nx1 : bench for mux_scan_nx1 across three configs      |
// |                   (4x1b, 4x8b, 3x8b) sharing one stimulus stream.  |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module tb_mux_scan_nx1;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, mode, start;
  logic [1:0]  S;
  logic [3:0]  dwell;
  logic [31:0] data;

  logic [3:0]  in_w1;
  logic [23:0] in_n3;
  assign in_w1 = data[3:0];
  assign in_n3 = data[23:0];

  logic        y_w1;
  logic [7:0]  y_w8, y_n3;
  logic [1:0]  ch_w1, ch_w8, ch_n3;
  logic        v_w1, v_w8, v_n3, b_w1, b_w8, b_n3, d_w1, d_w8, d_n3;

  mux_scan_nx1 #(.N_CH(4), .W(1), .DWELL_W(4)) u_w1 (
    .clk(clk), .rst(rst), .I(in_w1), .S(S), .mode(mode), .start(start), .dwell(dwell),
    .Y(y_w1), .ch(ch_w1), .valid(v_w1), .busy(b_w1), .scan_done(d_w1));

  mux_scan_nx1 #(.N_CH(4), .W(8), .DWELL_W(4)) u_w8 (
    .clk(clk), .rst(rst), .I(data), .S(S), .mode(mode), .start(start), .dwell(dwell),
    .Y(y_w8), .ch(ch_w8), .valid(v_w8), .busy(b_w8), .scan_done(d_w8));

  mux_scan_nx1 #(.N_CH(3), .W(8), .DWELL_W(4)) u_n3 (
    .clk(clk), .rst(rst), .I(in_n3), .S(S), .mode(mode), .start(start), .dwell(dwell),
    .Y(y_n3), .ch(ch_n3), .valid(v_n3), .busy(b_n3), .scan_done(d_n3));

  int n_vec = 0;
  int n_mis = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s @%0t: got %0h, expected %0h", nm, $time, act, exp);
    end
  endtask

  // Reference model: a sweep is a schedule of N*(dwell+1) slots; slot p shows channel p/(dwell+1).
  int          nch [3] = '{4, 4, 3};
  int          wid [3] = '{1, 8, 8};
  string       nm  [3] = '{"w1", "w8", "n3"};
  int          m_pos[3], m_len[3], m_d[3];
  logic [7:0]  m_y[3];
  logic [1:0]  m_ch[3];
  logic        m_v[3], m_b[3], m_dn[3];

  function automatic logic [7:0] chan(input int i, input logic [31:0] dat, input int c);
    if (c >= nch[i]) return 8'h00;
    if (wid[i] == 1) return 8'((dat >> c) & 32'h1);
    return 8'(dat >> (c * 8));
  endfunction

  task automatic model_step();
    for (int i = 0; i < 3; i++) begin
      if (rst) begin
        m_y[i] = '0; m_ch[i] = '0; m_v[i] = 0; m_b[i] = 0; m_dn[i] = 0;
        m_pos[i] = 0; m_len[i] = 0;
      end else if (m_pos[i] < m_len[i]) begin
        if (mode == 1'b0) begin
          m_pos[i] = m_len[i]; m_v[i] = 0; m_b[i] = 0; m_dn[i] = 0;
        end else begin
          int c;
          c = m_pos[i] / (m_d[i] + 1);
          m_pos[i]++;
          m_y[i]  = chan(i, data, c);
          m_ch[i] = 2'(c);
          m_v[i]  = 1;
          m_dn[i] = (m_pos[i] == m_len[i]);
          m_b[i]  = !m_dn[i];
        end
      end else begin
        m_dn[i] = 0; m_b[i] = 0;
        if (mode == 1'b0) begin
          m_ch[i] = S;
          m_y[i]  = chan(i, data, int'(S));
          m_v[i]  = (int'(S) < nch[i]);
        end else begin
          m_v[i] = 0;
          if (start) begin
            m_d[i] = int'(dwell); m_len[i] = nch[i] * (m_d[i] + 1); m_pos[i] = 0; m_b[i] = 1;
          end
        end
      end
    end
  endtask

  task automatic check_inst(input int i, input logic [7:0] y, input logic [1:0] c,
                            input logic v, input logic b, input logic d);
    chk($sformatf("%s.Y", nm[i]),         32'(y), 32'(m_y[i]));
    chk($sformatf("%s.ch", nm[i]),        32'(c), 32'(m_ch[i]));
    chk($sformatf("%s.valid", nm[i]),     32'(v), 32'(m_v[i]));
    chk($sformatf("%s.busy", nm[i]),      32'(b), 32'(m_b[i]));
    chk($sformatf("%s.scan_done", nm[i]), 32'(d), 32'(m_dn[i]));
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check_inst(0, {7'b0, y_w1}, ch_w1, v_w1, b_w1, d_w1);
    check_inst(1, y_w8, ch_w8, v_w8, b_w8, d_w8);
    check_inst(2, y_n3, ch_n3, v_n3, b_n3, d_n3);
  endtask

  typedef struct {
    logic [31:0] data;
    logic [1:0]  sel;
    logic [7:0]  exp_w1;
    logic [7:0]  exp_w8;
    logic [7:0]  exp_n3;
    logic        exp_vn3;
  } vec_t;

  vec_t        tbl[$];
  logic [7:0]  exp_a[4];

  initial begin
    exp_a = '{8'hA0, 8'hB1, 8'hC2, 8'hD3};
    for (int p = 0; p < 16; p++) begin
      for (int s = 0; s < 4; s++) begin
        vec_t v;
        v.data    = ($urandom & 32'hFFFF_FFF0) | 32'(p);
        v.sel     = 2'(s);
        v.exp_w1  = 8'((p >> s) & 1);
        v.exp_w8  = 8'(v.data >> (8 * s));
        v.exp_n3  = (s == 3) ? 8'h00 : v.exp_w8;
        v.exp_vn3 = (s != 3);
        tbl.push_back(v);
      end
    end
    tbl.push_back(vec_t'{32'hD3C2B1A4, 2'd2, 8'h01, 8'hC2, 8'hC2, 1'b1});
    tbl.push_back(vec_t'{32'hD3C2B1A0, 2'd3, 8'h00, 8'hD3, 8'h00, 1'b0});

    // Reset with busy-looking inputs everywhere
    rst = 1; mode = 0; start = 1; S = 2'd1; dwell = 4'd3; data = 32'hFFFF_FFFF;
    tick(); tick();
    chk("rst.Y", 32'(y_w8), 32'h0);
    chk("rst.valid", 32'(v_w8), 32'h0);
    chk("rst.busy", 32'(b_w8), 32'h0);
    rst = 0; start = 0;

    // Manual mode table
    mode = 0;
    foreach (tbl[k]) begin
      data = tbl[k].data; S = tbl[k].sel;
      tick();
      chk("tbl.w1.Y", 32'(y_w1), 32'(tbl[k].exp_w1));
      chk("tbl.w8.Y", 32'(y_w8), 32'(tbl[k].exp_w8));
      chk("tbl.w8.valid", 32'(v_w8), 32'h1);
      chk("tbl.n3.Y", 32'(y_n3), 32'(tbl[k].exp_n3));
      chk("tbl.n3.valid", 32'(v_n3), 32'(tbl[k].exp_vn3));
    end

    // Sweep with dwell=0
    mode = 1; data = 32'hD3C2B1A0; dwell = 0; start = 1; S = 0;
    tick();
    chk("s0.busy_start", 32'(b_w8), 32'h1);
    start = 0;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("s0.Y", 32'(y_w8), 32'(exp_a[k]));
      chk("s0.ch", 32'(ch_w8), 32'(k));
      chk("s0.busy", 32'(b_w8), (k < 3) ? 32'h1 : 32'h0);
      chk("s0.done", 32'(d_w8), (k < 3) ? 32'h0 : 32'h1);
      if (k == 2) chk("s0.n3.done", 32'(d_n3), 32'h1);
    end
    tick();
    chk("s0.valid_after", 32'(v_w8), 32'h0);
    chk("s0.done_once", 32'(d_w8), 32'h0);

    // Sweep with dwell=2, dwell input changed mid-sweep
    dwell = 2; start = 1;
    tick();
    start = 0; dwell = 0;
    for (int k = 0; k < 12; k++) begin
      tick();
      chk("s2.Y", 32'(y_w8), 32'(exp_a[k / 3]));
      chk("s2.done", 32'(d_w8), (k == 11) ? 32'h1 : 32'h0);
    end
    tick();

    // Back-to-back sweeps with start held high
    dwell = 0; start = 1;
    repeat (5) tick();
    chk("b2b.done", 32'(d_w8), 32'h1);
    tick();
    chk("b2b.restart", 32'(b_w8), 32'h1);
    start = 0;
    repeat (5) tick();

    // Abort while the sweep sits on channel 1
    S = 2'd3; dwell = 1; start = 1;
    tick();
    start = 0;
    tick(); tick();
    mode = 0;
    tick();
    chk("abort.busy", 32'(b_w8), 32'h0);
    chk("abort.done", 32'(d_w8), 32'h0);
    tick();
    chk("abort.Y", 32'(y_w8), 32'hD3);
    chk("abort.ch", 32'(ch_w8), 32'h3);
    chk("abort.valid", 32'(v_w8), 32'h1);
    chk("abort.n3.valid", 32'(v_n3), 32'h0);

    // Reset in the middle of a sweep, start held during reset
    mode = 1; dwell = 0; start = 1;
    tick();
    start = 0;
    tick(); tick();
    rst = 1; start = 1;
    tick();
    chk("rstmid.Y", 32'(y_w8), 32'h0);
    chk("rstmid.ch", 32'(ch_w8), 32'h0);
    chk("rstmid.valid", 32'(v_w8), 32'h0);
    chk("rstmid.busy", 32'(b_w8), 32'h0);
    tick();
    chk("rstmid.busy2", 32'(b_w8), 32'h0);
    rst = 0; start = 0;
    tick();

    // Randomized traffic against the model
    for (int n = 0; n < 400; n++) begin
      rst   = ($urandom_range(0, 49) == 0);
      mode  = ($urandom_range(0, 9) != 0);
      start = ($urandom_range(0, 3) == 0);
      dwell = 4'($urandom_range(0, 3));
      S     = 2'($urandom_range(0, 3));
      data  = $urandom;
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
`default_nettype wire
